// File: rtl/led_breathe_if.sv
// Handshake-free bundle between the breathe sequencer and its driver.
// The driver owns enable/tick; the sequencer owns the LED outputs.
interface led_breathe_if #(
    parameter int PWM_W = 4
);
    logic             enable;
    logic             tick;
    logic             led0;
    logic [PWM_W-1:0] level;
    logic             cycle_done;

    modport master (
        output enable,
        output tick,
        input  led0,
        input  level,
        input  cycle_done
    );

    modport slave (
        input  enable,
        input  tick,
        output led0,
        output level,
        output cycle_done
    );
endinterface

// File: rtl/led_breathe.sv
// Breathing-LED sequencer: ramps a PWM duty up, holds, ramps down, holds.
// Steps on the upstream one-cycle tick; every output comes from a flop.
module led_breathe #(
    parameter int PWM_W      = 4,
    parameter int HOLD_TICKS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    led_breathe_if.slave bus
);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PWM_W-1:0] ONE    = PWM_W'(1);
    localparam logic [PWM_W-1:0] MAX_M1 = PWM_W'((2 ** PWM_W) - 2);
    localparam logic [HW-1:0]    HONE   = HW'(1);
    localparam logic [HW-1:0]    HLAST  = HW'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } state_e;

    state_e           state_q, state_d;
    logic [PWM_W-1:0] level_q, level_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             hold_end;

    assign hold_end = bus.tick && (hold_q == HLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            pwm_q   <= '0;
            hold_q  <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            pwm_q   <= pwm_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        pwm_d   = pwm_q + ONE;
        led_d   = bus.enable && (pwm_q < level_q);
        // Dropping enable wins over any tick in the same cycle.
        if (!bus.enable) begin
            state_d = IDLE;
            level_d = '0;
            hold_d  = '0;
            pwm_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = UP;
                    level_d = '0;
                    hold_d  = '0;
                end
                UP: begin
                    if (bus.tick) begin
                        level_d = level_q + ONE;
                        if (level_q == MAX_M1) begin
                            state_d = HOLD_HI;
                            hold_d  = '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (bus.tick) begin
                        hold_d = hold_q + HONE;
                        if (hold_end) begin
                            hold_d  = '0;
                            state_d = DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (bus.tick) begin
                        level_d = level_q - ONE;
                        if (level_q == ONE) begin
                            state_d = HOLD_LO;
                            hold_d  = '0;
                        end
                    end
                end
                HOLD_LO: begin
                    if (bus.tick) begin
                        hold_d = hold_q + HONE;
                        if (hold_end) begin
                            hold_d  = '0;
                            state_d = UP;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign bus.led0       = led_q;
    assign bus.level      = level_q;
    assign bus.cycle_done = done_q;
endmodule

// File: tb/tb_led_breathe.sv
// Scoreboard bench for led_breathe: a cycle-position model predicts
// every output, a negedge monitor pops and compares.
module tb_led_breathe;
    localparam int MAXV = 15;
    localparam int H    = 2;
    localparam int P    = 2 * MAXV + 2 * H;

    typedef struct packed {
        logic       led0;
        logic [3:0] level;
        logic       done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;
    exp_t sb[$];

    led_breathe_if #(.PWM_W(4)) bus ();

    led_breathe #(
        .PWM_W     (4),
        .HOLD_TICKS(H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Level as a function of ticks counted since the cycle began.
    function automatic int lvl_of(input int k);
        if (k <= MAXV) return k;
        if (k <= MAXV + H) return MAXV;
        if (k <= 2 * MAXV + H) return 2 * MAXV + H - k;
        return 0;
    endfunction

    int   m_k      = 0;
    int   m_pwm    = 0;
    int   m_lvl    = 0;
    bit   m_active = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_k      = 0;
                m_pwm    = 0;
                m_lvl    = 0;
                m_active = 1'b0;
                sb.delete();
            end else begin
                e.led0 = bus.enable && (m_pwm < m_lvl);
                e.done = 1'b0;
                m_pwm  = bus.enable ? (m_pwm + 1) % 16 : 0;
                if (!bus.enable) begin
                    m_active = 1'b0;
                    m_k      = 0;
                end else if (!m_active) begin
                    m_active = 1'b1;
                    m_k      = 0;
                end else if (bus.tick) begin
                    m_k = m_k + 1;
                    if (m_k == P) begin
                        m_k    = 0;
                        e.done = 1'b1;
                    end
                end
                m_lvl   = m_active ? lvl_of(m_k) : 0;
                e.level = 4'(m_lvl);
                sb.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin
                e    = sb.pop_front();
                vecs = vecs + 1;
                if (bus.led0 !== e.led0 || bus.level !== e.level ||
                    bus.cycle_done !== e.done) begin
                    errs = errs + 1;
                    $display("FAIL out t=%0t: got led0=%b level=%0d done=%b, exp led0=%b level=%0d done=%b",
                             $time, bus.led0, bus.level, bus.cycle_done,
                             e.led0, e.level, e.done);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs = vecs + 1;
        if (got !== exp) begin
            errs = errs + 1;
            $display("FAIL %s t=%0t: got %0d, exp %0d", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic tk);
        @(negedge clk);
        #1;
        bus.enable = en;
        bus.tick   = tk;
    endtask

    task automatic duty(input int n);
        int cnt;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (n) step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        check("duty_level", 32'(bus.level), 32'(n));
        cnt = 0;
        repeat (16) begin
            step(1'b1, 1'b0);
            cnt = cnt + int'(bus.led0);
        end
        check("duty_count", 32'(cnt), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, exp $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.tick   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_led0", 32'(bus.led0), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_done", 32'(bus.cycle_done), 32'd0);
        #2 rst_n = 1'b1;

        // Ticks with enable low, then a tick on the enabling edge.
        repeat (10) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1);
        repeat (80) step(1'b1, 1'b1);

        // One tick every 16 clocks over two full cycles.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (70) begin
            step(1'b1, 1'b1);
            repeat (15) step(1'b1, 1'b0);
        end

        duty(5);
        duty(15);
        duty(0);

        // Abort in DOWN at level 9, then restart.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (23) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("down_level9", 32'(bus.level), 32'd9);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (40) step(1'b1, 1'($urandom_range(0, 1)));

        // Asynchronous reset mid-ramp at level 7.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (7) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("ramp_level7", 32'(bus.level), 32'd7);
        rst_n = 1'b0;
        #1;
        check("async_led0", 32'(bus.led0), 32'd0);
        check("async_level", 32'(bus.level), 32'd0);
        check("async_done", 32'(bus.cycle_done), 32'd0);
        #1 rst_n = 1'b1;
        repeat (20) step(1'b1, 1'($urandom_range(0, 1)));

        // Random run with rare enable drops.
        repeat (3000)
            step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)));

        repeat (3) step(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/led_breathe.md
# led_breathe

Breathing-LED sequencer that sits directly downstream of the `led_test` counter stage. It consumes that stage's one-cycle terminal-count `tick` and drives `led0` with a PWM duty cycle that ramps up, holds, ramps down and holds in a repeating pattern. The block runs in the same single clock domain and is board-visible in both RTL and gate-level simulation.

## Interface
- `PWM_W`, 4: PWM counter/level width; PWM period = 2^PWM_W clocks; MAX = 2^PWM_W-1.
- `HOLD_TICKS`, 2: ticks spent in each hold state; legal range ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock and one asynchronous active-low reset for the whole block.
- `enable`  in  1  run request; level-sensitive.
- `tick`  in  1  step pulse from upstream counter; sampled each clock.
- `led0`  out  1  registered PWM LED drive.
- `level`  out  PWM_W  current duty level, 0..MAX.
- `cycle_done`  out  1  one-clock pulse at end of each full breathe cycle.

## Operation
- Reset values: `led0`=0, `level`=0, `cycle_done`=0, state IDLE, `pwm_cnt`=0, `hold_cnt`=0.
- PWM counter `pwm_cnt` (PWM_W bits) increments every clock while `enable`=1 and wraps MAX→0. It is forced to 0 while `enable`=0.
- `led0` register loads `enable && (pwm_cnt < level)` each clock.
  - `level`=0 gives always off.
  - `level`=MAX gives on for MAX of every 2^PWM_W clocks.
- FSM states: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
  - IDLE: `level`=0. If `enable`=1, go to UP next clock. A `tick` in this cycle is ignored.
  - UP: on `tick`, `level`++. If `tick` and `level`==MAX-1, `level` becomes MAX, `hold_cnt` becomes 0, go to HOLD_HI.
  - HOLD_HI: on `tick`, `hold_cnt`++. If `tick` and `hold_cnt`==HOLD_TICKS-1, `hold_cnt` becomes 0, go to DOWN.
  - DOWN: on `tick`, `level`--. If `tick` and `level`==1, `level` becomes 0, go to HOLD_LO.
  - HOLD_LO: same as HOLD_HI. On exit, go to UP and pulse `cycle_done` for exactly that clock.
- `enable`=0 in any state takes priority over `tick`. Next clock: state IDLE, `level`=0, `hold_cnt`=0, `pwm_cnt`=0, `led0`=0.
- `level` never wraps; MAX and 0 are reached only through state transitions.
- `tick` is not edge-detected. A `tick` held high advances one step per clock.

## Timing
- `tick` sampled at edge N updates `level` at edge N. `led0` reflects the new `level` from edge N+1 (one register stage).
- `led0` is glitch-free: it is driven directly from a flop.
- `enable` 0→1 at edge N moves to UP at edge N. The first counted `tick` is at edge N+1 or later.
- Full cycle with steady ticks = 2·MAX + 2·HOLD_TICKS ticks (34 for defaults).
- `cycle_done` is high for exactly one clock, coincident with the HOLD_LO→UP edge.
- Asserting `rst_n`=0 at any time clears all outputs immediately, without waiting for a clock edge.
- Release of `rst_n` is assumed synchronous to `clk` at system level. The first state change can occur on the first rising edge after release.

## Test plan
- Reset mid-ramp: hold `enable`=1 until `level`=7, then pulse `rst_n`=0 between clock edges → `led0`, `level` and `cycle_done` go to 0 without a clock edge. After release, the block stays in IDLE until the next edge with `enable`=1.
- Full cycle (defaults, one `tick` every 16 clocks):
  - `level` steps 0→15 over 15 ticks, holds 15 for 2 ticks, steps 15→0 over 15 ticks, holds 0 for 2 ticks.
  - `cycle_done` pulses once on the 34th tick; the pattern then repeats.
- Duty check: apply 5 ticks then none → `level`=5; over any aligned 16-clock window `led0` is high exactly 5 clocks. Same check at `level`=15 → high 15 of 16, and at `level`=0 → never high.
- Enable drop: deassert `enable` in DOWN at `level`=9 → next clock `level`=0 and `led0`=0. Re-assert `enable` → ramp restarts from 0 in UP, and no `cycle_done` is produced for the aborted cycle.
- Continuous `tick`=1 with `enable`=1 → `level` increments every clock and reaches 15 after 15 clocks in UP. First `cycle_done` appears 34 clocks after the first counted tick.
- Ticks while `enable`=0, and the tick on the same edge as `enable` rising, are ignored → `level` stays 0 and the state stays IDLE (respectively just enters UP).
